perip_dma: RTL and testbench

//  Bus initiator (word copy engine) on the peripheral memory bus, the master-side counterpart of the address-decoding responder.

---
 rtl/perip_dma.sv | 180 ++++++++++++++++++
 tb/tb_perip_dma.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/perip_dma.sv
// rtl/perip_dma.sv - word copy engine acting as initiator on the peripheral memory bus
//
// Purpose: copies len_i 32-bit words from src_addr_i to dst_addr_i, one read
// and one write per word, after requesting bus ownership from the core.
// Optional feature macro: PERIP_DMA_FILL_EN (fill_i=1 writes fill_val_i to
// every destination word, 1 cycle/word, no reads).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i                       1-cycle job request, sampled only in IDLE
//   src_addr_i, dst_addr_i        word-aligned byte addresses
//   len_i                         number of words (0 = immediate done)
//   fill_i, fill_val_i            fill mode select and fill word
//   busy_o, done_o, err_o         status: job active, completion pulse, misalignment pulse
//   bus_req_o, bus_gnt_i          bus ownership handshake with the core
//   mem_rw_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i      memory bus (rdata valid the cycle after address)
module perip_dma #(
    parameter int LEN_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             fill_i,
    input  logic [31:0]      fill_val_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             bus_req_o,
    input  logic             bus_gnt_i,
    output logic             mem_rw_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_RDW  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [31:0]        buf_q, buf_d;
    logic [31:0]        addr_q, addr_d;
    logic               err_q, err_d;
    logic               fill_mode;
    logic               start_fill;

`ifdef PERIP_DMA_FILL_EN
    logic fill_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q <= 1'b0;
        end else if (state_q == S_IDLE && start_i) begin
            fill_q <= fill_i;
        end
    end

    assign fill_mode  = fill_q;
    assign start_fill = fill_i;
`else
    logic unused_fill;
    assign unused_fill = ^{fill_i, fill_val_i};
    assign fill_mode   = 1'b0;
    assign start_fill  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        buf_d     = buf_q;
        addr_d    = addr_q;   // bus address holds its last value when not driven
        err_d     = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        bus_req_o = 1'b0;
        mem_rw_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // Fill jobs never read, so only the destination must be aligned.
                    if ((dst_addr_i[1:0] != 2'b00) ||
                        (!start_fill && src_addr_i[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end else begin
                        src_d = src_addr_i;
                        dst_d = dst_addr_i;
                        rem_d = len_i;
`ifdef PERIP_DMA_FILL_EN
                        if (fill_i) buf_d = fill_val_i;
`endif
                        state_d = (len_i == '0) ? S_DONE : S_REQ;
                    end
                end
            end
            S_REQ: begin
                busy_o    = 1'b1;
                bus_req_o = 1'b1;
                if (bus_gnt_i) state_d = fill_mode ? S_WR : S_RD;
            end
            S_RD: begin
                busy_o    = 1'b1;
                bus_req_o = 1'b1;
                addr_d    = src_q;
                if (bus_gnt_i) state_d = S_RDW;
            end
            S_RDW: begin
                busy_o    = 1'b1;
                bus_req_o = 1'b1;
                addr_d    = src_q;
                // Without grant the returned data belongs to the core's access,
                // so the read is reissued from RD.
                if (bus_gnt_i) begin
                    buf_d   = mem_rdata_i;
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_WR: begin
                busy_o    = 1'b1;
                bus_req_o = 1'b1;
                addr_d    = dst_q;
                if (bus_gnt_i) begin
                    mem_rw_o = 1'b1;
                    src_d    = src_q + 32'(ADDR_STEP);
                    dst_d    = dst_q + 32'(ADDR_STEP);
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = S_DONE;
                    else                    state_d = fill_mode ? S_WR : S_RD;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_o       = err_q;
    assign mem_addr_o  = addr_d;
    assign mem_wdata_o = buf_q;

endmodule

// File: tb/tb_perip_dma.sv
// tb/tb_perip_dma.sv - directed self-checking bench for perip_dma
module tb_perip_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        fill = 1'b0;
    logic [31:0] fill_val = '0;
    logic        busy, done, err, bus_req, mem_rw;
    logic        gnt = 1'b1;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    perip_dma #(.LEN_W(16), .ADDR_STEP(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .src_addr_i  (src),
        .dst_addr_i  (dst),
        .len_i       (len),
        .fill_i      (fill),
        .fill_val_i  (fill_val),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .bus_req_o   (bus_req),
        .bus_gnt_i   (gnt),
        .mem_rw_o    (mem_rw),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (rdata)
    );

    // Memory responder: 256 words covering byte addresses 0x000-0x3FC (wrapping).
    logic [31:0] ram [256];
    logic        ram_init = 1'b0;
    int          wr_total = 0;
    int          bad_wr = 0;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            'h40: return 32'h0000000A;
            'h41: return 32'h0000000B;
            'h42: return 32'h0000000C;
            'h43: return 32'h0000000D;
            'h44: return 32'h0000000E;
            'h45: return 32'h0000000F;
            'h50: return 32'h00001000;
            'h51: return 32'h00001001;
            'h52: return 32'h00001002;
            'h53: return 32'h00001003;
            'hFF: return 32'h11112222;
            'h00: return 32'h33334444;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else if (mem_rw) begin
            if (gnt) begin
                ram[mem_addr[9:2]] <= mem_wdata;
                wr_total <= wr_total + 1;
            end else begin
                bad_wr <= bad_wr + 1;
            end
        end
        rdata <= gnt ? ram[mem_addr[9:2]] : 32'hBAD0BAD0;
    end

    // Starts a job on a negedge and waits for done/err; gnt is low for
    // cycles lo_from..lo_to (cycle 0 = start cycle).
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                           input logic f, input logic [31:0] fv, input int lo_from, input int lo_to,
                           output int lat, output int busy_n, output bit req_seen, output bit err_seen);
        int n;
        @(negedge clk);
        src = s; dst = d; len = l; fill = f; fill_val = fv; start = 1'b1; gnt = 1'b1;
        n = 0; busy_n = 0; req_seen = 0; err_seen = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
            gnt = !(n >= lo_from && n <= lo_to);
            if (busy) busy_n++;
            if (bus_req) req_seen = 1;
            if (err) err_seen = 1;
        end while (!done && !err && n < 100);
        gnt = 1'b1;
        lat = n;
        if (n >= 100) begin
            errors++; checks++;
            $display("FAIL job_timeout: no done/err after %0d cycles, required completion", n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        checks++; if (mem_rw !== 1'b0)  begin errors++; $display("FAIL reset_mem_rw: got %b want 0", mem_rw); end
        checks++; if (mem_addr !== 32'h0)  begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_copy;
        int lat, bn, w0; bit rq, es;
        w0 = wr_total;
        run_job(32'h100, 32'h200, 16'd3, 1'b0, 32'h0, -1, -1, lat, bn, rq, es);
        checks++; if (lat !== 11) begin errors++; $display("FAIL copy_latency: got %0d want 11", lat); end
        checks++; if (bn !== 10)  begin errors++; $display("FAIL copy_busy_cycles: got %0d want 10", bn); end
        checks++; if (wr_total - w0 !== 3) begin errors++; $display("FAIL copy_writes: got %0d want 3", wr_total - w0); end
        checks++; if (ram['h80] !== 32'hA) begin errors++; $display("FAIL copy_w0: got %h want a", ram['h80]); end
        checks++; if (ram['h81] !== 32'hB) begin errors++; $display("FAIL copy_w1: got %h want b", ram['h81]); end
        checks++; if (ram['h82] !== 32'hC) begin errors++; $display("FAIL copy_w2: got %h want c", ram['h82]); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL copy_after_done: done=%b busy=%b req=%b want 0 0 0", done, busy, bus_req);
        end
    endtask

    task automatic test_len_zero;
        int lat, bn, w0; bit rq, es;
        w0 = wr_total;
        run_job(32'h100, 32'h200, 16'd0, 1'b0, 32'h0, -1, -1, lat, bn, rq, es);
        checks++; if (lat !== 1)   begin errors++; $display("FAIL len0_latency: got %0d want 1", lat); end
        checks++; if (rq !== 1'b0) begin errors++; $display("FAIL len0_bus_req: got %b want 0", rq); end
        checks++; if (wr_total - w0 !== 0) begin errors++; $display("FAIL len0_writes: got %0d want 0", wr_total - w0); end
    endtask

    task automatic test_misaligned;
        int lat, bn; bit rq, es;
        run_job(32'h102, 32'h200, 16'd2, 1'b0, 32'h0, -1, -1, lat, bn, rq, es);
        checks++; if (es !== 1'b1 || lat !== 1) begin errors++; $display("FAIL misalign_err: got err=%b lat=%0d want 1 1", es, lat); end
        checks++; if (bn !== 0 || rq !== 1'b0) begin errors++; $display("FAIL misalign_quiet: got busy=%0d req=%b want 0 0", bn, rq); end
        @(negedge clk);
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got err=%b busy=%b want 0 0", err, busy); end
    endtask

    task automatic test_grant_loss;
        int lat, bn, w0; bit rq, es;
        w0 = wr_total;
        run_job(32'h140, 32'h240, 16'd4, 1'b0, 32'h0, 5, 9, lat, bn, rq, es);
        checks++; if (lat !== 19) begin errors++; $display("FAIL gnt_latency: got %0d want 19", lat); end
        checks++; if (bad_wr !== 0) begin errors++; $display("FAIL gnt_write_without_grant: got %0d want 0", bad_wr); end
        checks++; if (wr_total - w0 !== 4) begin errors++; $display("FAIL gnt_writes: got %0d want 4", wr_total - w0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram['h90 + i] !== 32'h1000 + 32'(i)) begin
                errors++; $display("FAIL gnt_word%0d: got %h want %h", i, ram['h90 + i], 32'h1000 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid_job;
        int w0, lat, bn; bit rq, es;
        w0 = wr_total;
        @(negedge clk);
        src = 32'h100; dst = 32'h2C0; len = 16'd8; fill = 1'b0; start = 1'b1; gnt = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 6) rst = 1'b1;
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus_req !== 1'b0 || mem_rw !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: busy=%b req=%b rw=%b done=%b want 0 0 0 0", busy, bus_req, mem_rw, done);
        end
        rst = 1'b0;
        checks++; if (wr_total - w0 !== 1) begin errors++; $display("FAIL rstmid_writes: got %0d want 1", wr_total - w0); end
        checks++; if (ram['hB0] !== 32'hA || ram['hB1] !== 32'h0) begin
            errors++; $display("FAIL rstmid_mem: got %h %h want a 0", ram['hB0], ram['hB1]);
        end
        run_job(32'h100, 32'h340, 16'd2, 1'b0, 32'h0, -1, -1, lat, bn, rq, es);
        checks++; if (lat !== 8) begin errors++; $display("FAIL rstmid_rerun_latency: got %0d want 8", lat); end
        checks++; if (ram['hD0] !== 32'hA || ram['hD1] !== 32'hB) begin
            errors++; $display("FAIL rstmid_rerun_mem: got %h %h want a b", ram['hD0], ram['hD1]);
        end
    endtask

    task automatic test_addr_wrap;
        int lat, bn; bit rq, es;
        run_job(32'hFFFFFFFC, 32'h380, 16'd2, 1'b0, 32'h0, -1, -1, lat, bn, rq, es);
        checks++; if (lat !== 8) begin errors++; $display("FAIL wrap_latency: got %0d want 8", lat); end
        checks++; if (ram['hE0] !== 32'h11112222) begin errors++; $display("FAIL wrap_w0: got %h want 11112222", ram['hE0]); end
        checks++; if (ram['hE1] !== 32'h33334444) begin errors++; $display("FAIL wrap_w1: got %h want 33334444", ram['hE1]); end
    endtask

`ifdef PERIP_DMA_FILL_EN
    task automatic test_fill;
        int lat, bn, w0; bit rq, es;
        w0 = wr_total;
        run_job(32'h102, 32'h300, 16'd4, 1'b1, 32'hDEADBEEF, -1, -1, lat, bn, rq, es);
        checks++; if (lat !== 6 || es !== 1'b0) begin errors++; $display("FAIL fill_latency: got %0d err=%b want 6 0", lat, es); end
        checks++; if (wr_total - w0 !== 4) begin errors++; $display("FAIL fill_writes: got %0d want 4", wr_total - w0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram['hC0 + i] !== 32'hDEADBEEF) begin
                errors++; $display("FAIL fill_word%0d: got %h want deadbeef", i, ram['hC0 + i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_copy;
        test_len_zero;
        test_misaligned;
        test_grant_loss;
        test_reset_mid_job;
        test_addr_wrap;
`ifdef PERIP_DMA_FILL_EN
        test_fill;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
